// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and FSM state types for the sequenced ALU stage
package alu_pkg;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_ADC = 2'b10,
    ALU_MUL = 2'b11
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, EXEC, MUL_IT, DONE} alu_state_t;
endpackage

// File: rtl/ripple_adder_n.sv
// ripple_adder_n: WIDTH-bit ripple-carry adder built from a chain of full adders
module ripple_adder_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[WIDTH];
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU stage doing ADD/SUB/ADC in one pass and MUL by shift-add over one shared adder
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_c,
  output logic               flag_z,
  output logic               flag_v
);
  localparam int CW = $clog2(WIDTH + 1);
  alu_state_t state, state_n;
  alu_op_t op_r;
  logic [WIDTH-1:0] a_r, b_r, hi, lo, x, y, sum;
  logic [CW-1:0] cnt;
  logic cin, cout;
  ripple_adder_n #(.WIDTH(WIDTH)) u_add (.a(x), .b(y), .cin(cin), .sum(sum), .cout(cout));
  // MUL keeps the multiplier in lo; its LSB selects the partial product each pass
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    result    = {hi, lo};
    x   = state == MUL_IT ? hi : a_r;
    y   = state == MUL_IT ? (lo[0] ? a_r : '0) : (op_r == ALU_SUB ? ~b_r : b_r);
    cin = state == MUL_IT ? 1'b0 : op_r == ALU_SUB ? 1'b1 : op_r == ALU_ADC ? flag_c : 1'b0;
    state_n = state == IDLE   ? (in_valid ? (op == ALU_MUL ? MUL_IT : EXEC) : IDLE) :
              state == EXEC   ? DONE :
              state == MUL_IT ? (cnt == CW'(1) ? DONE : MUL_IT) :
                                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= ALU_ADD;
      a_r    <= '0;
      b_r    <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        op_r <= alu_op_t'(op);
        a_r  <= a;
        b_r  <= b;
        hi   <= '0;
        lo   <= b;
        cnt  <= CW'(WIDTH);
      end
      if (state == EXEC) begin
        hi     <= '0;
        lo     <= sum;
        flag_c <= cout;
        flag_z <= sum == '0;
        flag_v <= (a_r[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      if (state == MUL_IT) begin
        hi  <= {cout, sum[WIDTH-1:1]};
        lo  <= {sum[0], lo[WIDTH-1:1]};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          flag_z <= {cout, sum, lo[WIDTH-1:1]} == '0;
          flag_v <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed vector table plus backpressure and mid-multiply reset sequences
module tb_alu_seq_unit;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [1:0] op = 0;
  logic [3:0] a = 0, b = 0;
  logic in_ready, out_valid, flag_c, flag_z, flag_v;
  logic [7:0] result;
  int tests = 0, fails = 0;

  alu_seq_unit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] a, b;
    logic [7:0] res;
    logic c, z, v;
    int lat;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // latency counts clock edges from the accepting edge to the edge that first samples out_valid=1
  task automatic run(input logic [1:0] o, input logic [3:0] aa, input logic [3:0] bb,
                     output logic [7:0] r, output logic c, output logic z, output logic v, output int lat);
    int n;
    @(negedge clk);
    op = o; a = aa; b = bb; in_valid = 1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    r = result; c = flag_c; z = flag_z; v = flag_v;
  endtask

  initial begin
    logic [7:0] r;
    logic c, z, v;
    int lat;
    bit seen;
    vt[0]  = '{2'b00, 4'h5, 4'h3, 8'h08, 0, 0, 1, 2};
    vt[1]  = '{2'b00, 4'hF, 4'h1, 8'h00, 1, 1, 0, 2};
    vt[2]  = '{2'b10, 4'h2, 4'h3, 8'h06, 0, 0, 0, 2};
    vt[3]  = '{2'b10, 4'h7, 4'h8, 8'h0F, 0, 0, 0, 2};
    vt[4]  = '{2'b01, 4'h3, 4'h5, 8'h0E, 0, 0, 0, 2};
    vt[5]  = '{2'b01, 4'h5, 4'h5, 8'h00, 1, 1, 0, 2};
    vt[6]  = '{2'b11, 4'hF, 4'hF, 8'hE1, 1, 0, 0, 5};
    vt[7]  = '{2'b11, 4'h3, 4'h0, 8'h00, 1, 1, 0, 5};
    vt[8]  = '{2'b01, 4'h8, 4'h1, 8'h07, 1, 0, 1, 2};
    vt[9]  = '{2'b10, 4'h7, 4'h0, 8'h08, 0, 0, 1, 2};
    vt[10] = '{2'b11, 4'h5, 4'h3, 8'h0F, 0, 0, 0, 5};
    vt[11] = '{2'b00, 4'h0, 4'h0, 8'h00, 0, 1, 0, 2};

    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_result", 32'(result), 0);
    chk("reset_flags", 32'({flag_c, flag_z, flag_v}), 0);

    for (int i = 0; i < 12; i++) begin
      run(vt[i].op, vt[i].a, vt[i].b, r, c, z, v, lat);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(vt[i].res));
      chk($sformatf("vec%0d_c", i), 32'(c), 32'(vt[i].c));
      chk($sformatf("vec%0d_z", i), 32'(z), 32'(vt[i].z));
      chk($sformatf("vec%0d_v", i), 32'(v), 32'(vt[i].v));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    end
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_in_ready", 32'(in_ready), 1);

    out_ready = 0;
    run(2'b00, 4'h5, 4'h3, r, c, z, v, lat);
    chk("bp_latency", 32'(lat), 2);
    op = 2'b00; a = 4'h1; b = 4'h1; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_result", 32'(result), 32'h08);
      chk("bp_flags", 32'({flag_c, flag_z, flag_v}), 32'b001);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 0);
    chk("bp_release_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    chk("bp_held_accepted", 32'(in_ready), 0);
    @(negedge clk);
    chk("bp_held_valid", 32'(out_valid), 1);
    chk("bp_held_result", 32'(result), 32'h02);

    run(2'b00, 4'hF, 4'h1, r, c, z, v, lat);
    chk("pre_rst_c", 32'(c), 1);
    @(negedge clk);
    op = 2'b11; a = 4'hF; b = 4'hF; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_in_ready", 32'(in_ready), 1);
    chk("rst_mid_c", 32'(flag_c), 0);
    chk("rst_mid_result", 32'(result), 0);
    seen = 0;
    repeat (6) begin @(negedge clk); seen |= out_valid; end
    chk("rst_mid_no_output", 32'(seen), 0);
    run(2'b00, 4'h2, 4'h2, r, c, z, v, lat);
    chk("post_rst_result", 32'(r), 32'h04);
    chk("post_rst_flags", 32'({c, z, v}), 0);
    chk("post_rst_latency", 32'(lat), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
